// File: rtl/ctrlport_spi_sequencer.sv
//==============================================================================
// Module   : ctrlport_spi_sequencer
// Purpose  : ControlPort master that runs one SPI command as a register
//            sequence on the SPI master block and returns the received word.
// Revision : 1.0
//==============================================================================
`default_nettype none

module ctrlport_spi_sequencer #(
  parameter int         BASE_ADDRESS = 0,
  parameter logic [7:0] CLK_DIVIDER  = 8'd2,
  parameter int         ACK_TIMEOUT  = 255,
  parameter int         MAX_POLLS    = 1023
) (
  input  logic        ctrlport_clk,
  input  logic        ctrlport_rst_n,
  input  logic        s_cmd_valid,
  output logic        s_cmd_ready,
  input  logic [3:0]  s_cmd_slave,
  input  logic [5:0]  s_cmd_bits,
  input  logic [31:0] s_cmd_data,
  output logic        m_rsp_valid,
  input  logic        m_rsp_ready,
  output logic [31:0] m_rsp_data,
  output logic [1:0]  m_rsp_status,
  output logic        m_ctrlport_req_wr,
  output logic        m_ctrlport_req_rd,
  output logic [19:0] m_ctrlport_req_addr,
  output logic [31:0] m_ctrlport_req_data,
  input  logic        m_ctrlport_resp_ack,
  input  logic [1:0]  m_ctrlport_resp_status,
  input  logic [31:0] m_ctrlport_resp_data
);

  localparam int c_ACK_W  = $clog2(ACK_TIMEOUT) + 1;
  localparam int c_POLL_W = $clog2(MAX_POLLS) + 1;

  localparam logic [c_ACK_W-1:0]  c_ACK_LIMIT  = c_ACK_W'(ACK_TIMEOUT);
  localparam logic [c_POLL_W-1:0] c_POLL_LIMIT = c_POLL_W'(MAX_POLLS);
  localparam logic [19:0]         c_BASE       = 20'(BASE_ADDRESS);

  localparam logic [1:0] c_ST_OK       = 2'd0;
  localparam logic [1:0] c_ST_CMDERR   = 2'd1;
  localparam logic [1:0] c_ST_ACK_TO   = 2'd2;
  localparam logic [1:0] c_ST_BUSY_TO  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_RESP     = 2'd3
  } state_t;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [19:0] addr;
    logic [31:0] data;
  } req_t;

  state_t              r_state;
  logic [2:0]          r_step;
  logic [3:0]          r_slave;
  logic [5:0]          r_bits;
  logic [31:0]         r_data;
  logic [c_ACK_W-1:0]  r_ack_cnt;
  logic [c_POLL_W-1:0] r_poll_cnt;
  req_t                r_req;

  logic                w_cmd_bad;
  logic [31:0]         w_rx_mask;
  logic [c_POLL_W-1:0] w_poll_next;

  assign m_ctrlport_req_wr   = r_req.wr;
  assign m_ctrlport_req_rd   = r_req.rd;
  assign m_ctrlport_req_addr = r_req.addr;
  assign m_ctrlport_req_data = r_req.data;

  assign w_cmd_bad   = (s_cmd_bits == 6'd0) || (s_cmd_bits > 6'd32);
  assign w_rx_mask   = (r_bits >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << r_bits) - 32'd1);
  assign w_poll_next = r_poll_cnt + c_POLL_W'(1);

  // Register access for a given step; CTRL selects ASS + TX_NEG (SPI mode 0).
  function automatic req_t f_req(input logic [2:0]  step,
                                 input logic [3:0]  slave,
                                 input logic [5:0]  bits,
                                 input logic [31:0] data);
    req_t        v;
    logic [31:0] ctrl;
    ctrl = 32'h0000_2400 | {25'd0, 1'b0, bits};
    v    = '0;
    case (step)
      3'd0:    begin v.wr = 1'b1; v.addr = c_BASE + 20'h14; v.data = {24'd0, CLK_DIVIDER}; end
      3'd1:    begin v.wr = 1'b1; v.addr = c_BASE + 20'h18; v.data = 32'd1 << slave; end
      3'd2:    begin v.wr = 1'b1; v.addr = c_BASE + 20'h08; v.data = data; end
      3'd3:    begin v.wr = 1'b1; v.addr = c_BASE + 20'h10; v.data = ctrl; end
      3'd4:    begin v.wr = 1'b1; v.addr = c_BASE + 20'h10; v.data = ctrl | 32'h0000_0100; end
      3'd5:    begin v.rd = 1'b1; v.addr = c_BASE + 20'h10; end
      default: begin v.rd = 1'b1; v.addr = c_BASE; end
    endcase
    return v;
  endfunction

  always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
    if (!ctrlport_rst_n) begin
      r_state      <= ST_IDLE;
      r_step       <= 3'd0;
      r_slave      <= 4'd0;
      r_bits       <= 6'd0;
      r_data       <= 32'd0;
      r_ack_cnt    <= '0;
      r_poll_cnt   <= '0;
      r_req        <= '0;
      s_cmd_ready  <= 1'b0;
      m_rsp_valid  <= 1'b0;
      m_rsp_data   <= 32'd0;
      m_rsp_status <= 2'd0;
    end else begin
      // Strobes last exactly one cycle unless a branch below issues the next one.
      r_req <= '0;
      case (r_state)
        ST_IDLE: begin
          s_cmd_ready <= 1'b1;
          if (s_cmd_valid && s_cmd_ready) begin
            s_cmd_ready <= 1'b0;
            r_slave     <= s_cmd_slave;
            r_bits      <= s_cmd_bits;
            r_data      <= s_cmd_data;
            r_step      <= 3'd0;
            r_ack_cnt   <= '0;
            r_poll_cnt  <= '0;
            if (w_cmd_bad) begin
              r_state      <= ST_RESP;
              m_rsp_valid  <= 1'b1;
              m_rsp_status <= c_ST_CMDERR;
              m_rsp_data   <= 32'd0;
            end else begin
              r_state <= ST_ISSUE;
              r_req   <= f_req(3'd0, s_cmd_slave, s_cmd_bits, s_cmd_data);
            end
          end
        end

        ST_ISSUE: begin
          r_ack_cnt <= '0;
          r_state   <= ST_WAIT_ACK;
        end

        ST_WAIT_ACK: begin
          if (m_ctrlport_resp_ack) begin
            if (m_ctrlport_resp_status != 2'd0) begin
              r_state      <= ST_RESP;
              m_rsp_valid  <= 1'b1;
              m_rsp_status <= c_ST_CMDERR;
              m_rsp_data   <= m_ctrlport_resp_data;
            end else if (r_step == 3'd6) begin
              r_state      <= ST_RESP;
              m_rsp_valid  <= 1'b1;
              m_rsp_status <= c_ST_OK;
              m_rsp_data   <= m_ctrlport_resp_data & w_rx_mask;
            end else if (r_step == 3'd5) begin
              if (!m_ctrlport_resp_data[8]) begin
                r_step  <= 3'd6;
                r_state <= ST_ISSUE;
                r_req   <= f_req(3'd6, r_slave, r_bits, r_data);
              end else if (w_poll_next >= c_POLL_LIMIT) begin
                r_state      <= ST_RESP;
                m_rsp_valid  <= 1'b1;
                m_rsp_status <= c_ST_BUSY_TO;
                m_rsp_data   <= 32'd0;
              end else begin
                r_poll_cnt <= w_poll_next;
                r_state    <= ST_ISSUE;
                r_req      <= f_req(3'd5, r_slave, r_bits, r_data);
              end
            end else begin
              r_step  <= r_step + 3'd1;
              r_state <= ST_ISSUE;
              r_req   <= f_req(r_step + 3'd1, r_slave, r_bits, r_data);
            end
          end else if (r_ack_cnt >= c_ACK_LIMIT) begin
            r_state      <= ST_RESP;
            m_rsp_valid  <= 1'b1;
            m_rsp_status <= c_ST_ACK_TO;
            m_rsp_data   <= 32'd0;
          end else begin
            r_ack_cnt <= r_ack_cnt + c_ACK_W'(1);
          end
        end

        ST_RESP: begin
          if (m_rsp_ready) begin
            m_rsp_valid <= 1'b0;
            s_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ctrlport_spi_sequencer.sv
//==============================================================================
// Module   : tb_ctrlport_spi_sequencer
// Purpose  : Randomized bench for ctrlport_spi_sequencer with a register-level
//            slave model and a sequence-level reference model.
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ctrlport_spi_sequencer;

  localparam logic [19:0] c_BASE        = 20'h00100;
  localparam int          c_ACK_TIMEOUT = 8;
  localparam int          c_MAX_POLLS   = 4;

  logic        ctrlport_clk   = 1'b0;
  logic        ctrlport_rst_n = 1'b1;
  logic        s_cmd_valid    = 1'b0;
  logic        s_cmd_ready;
  logic [3:0]  s_cmd_slave    = 4'd0;
  logic [5:0]  s_cmd_bits     = 6'd0;
  logic [31:0] s_cmd_data     = 32'd0;
  logic        m_rsp_valid;
  logic        m_rsp_ready    = 1'b0;
  logic [31:0] m_rsp_data;
  logic [1:0]  m_rsp_status;
  logic        m_ctrlport_req_wr;
  logic        m_ctrlport_req_rd;
  logic [19:0] m_ctrlport_req_addr;
  logic [31:0] m_ctrlport_req_data;
  logic        m_ctrlport_resp_ack    = 1'b0;
  logic [1:0]  m_ctrlport_resp_status = 2'd0;
  logic [31:0] m_ctrlport_resp_data   = 32'd0;

  ctrlport_spi_sequencer #(
    .BASE_ADDRESS (32'h100),
    .CLK_DIVIDER  (8'd2),
    .ACK_TIMEOUT  (c_ACK_TIMEOUT),
    .MAX_POLLS    (c_MAX_POLLS)
  ) u_dut (
    .ctrlport_clk           (ctrlport_clk),
    .ctrlport_rst_n         (ctrlport_rst_n),
    .s_cmd_valid            (s_cmd_valid),
    .s_cmd_ready            (s_cmd_ready),
    .s_cmd_slave            (s_cmd_slave),
    .s_cmd_bits             (s_cmd_bits),
    .s_cmd_data             (s_cmd_data),
    .m_rsp_valid            (m_rsp_valid),
    .m_rsp_ready            (m_rsp_ready),
    .m_rsp_data             (m_rsp_data),
    .m_rsp_status           (m_rsp_status),
    .m_ctrlport_req_wr      (m_ctrlport_req_wr),
    .m_ctrlport_req_rd      (m_ctrlport_req_rd),
    .m_ctrlport_req_addr    (m_ctrlport_req_addr),
    .m_ctrlport_req_data    (m_ctrlport_req_data),
    .m_ctrlport_resp_ack    (m_ctrlport_resp_ack),
    .m_ctrlport_resp_status (m_ctrlport_resp_status),
    .m_ctrlport_resp_data   (m_ctrlport_resp_data)
  );

  always #5 ctrlport_clk = ~ctrlport_clk;

  typedef struct packed {
    logic [1:0]  kind;   // {wr, rd}
    logic [19:0] addr;
    logic [31:0] data;
  } req_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always @(posedge ctrlport_clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Slave behaviour for the current command.
  int          cfg_busy      = 0;
  int          cfg_err_idx   = -1;
  int          cfg_noack_idx = -1;
  logic [31:0] cfg_rx        = 32'd0;
  logic [31:0] cfg_err_data  = 32'd0;
  int          slv_idx       = 0;
  int          slv_polls     = 0;
  bit          stray_req     = 1'b0;
  int          slv_cur;
  int          slv_dly;
  logic [31:0] slv_d;
  logic [1:0]  slv_st;

  req_t got_q[$];
  req_t exp_q[$];
  int   last_strobe_cyc = 0;
  logic [1:0]  exp_status;
  logic [31:0] exp_data;
  bit          exp_timeout;

  // Request monitor: every strobed cycle is logged.
  initial begin
    forever begin
      @(negedge ctrlport_clk);
      if (m_ctrlport_req_wr || m_ctrlport_req_rd) begin
        got_q.push_back({m_ctrlport_req_wr, m_ctrlport_req_rd, m_ctrlport_req_addr, m_ctrlport_req_data});
        last_strobe_cyc = cyc;
      end
    end
  end

  // Register-block model: CONTROL bit 8 is busy, base+0 is the RX register.
  initial begin
    forever begin
      @(negedge ctrlport_clk);
      m_ctrlport_resp_ack    = 1'b0;
      m_ctrlport_resp_status = 2'd0;
      m_ctrlport_resp_data   = 32'd0;
      if (m_ctrlport_req_wr || m_ctrlport_req_rd) begin
        slv_cur = slv_idx;
        slv_idx++;
        slv_st  = 2'd0;
        slv_d   = $urandom;
        if (m_ctrlport_req_rd && m_ctrlport_req_addr == c_BASE + 20'h10) begin
          slv_d = (slv_polls < cfg_busy) ? (slv_d | 32'h100) : (slv_d & ~32'h100);
          slv_polls++;
        end else if (m_ctrlport_req_rd && m_ctrlport_req_addr == c_BASE) begin
          slv_d = cfg_rx;
        end
        if (slv_cur == cfg_err_idx) begin
          slv_st = 2'($urandom_range(1, 3));
          slv_d  = cfg_err_data;
        end
        if (slv_cur != cfg_noack_idx) begin
          slv_dly = $urandom_range(1, 3);
          repeat (slv_dly) @(negedge ctrlport_clk);
          m_ctrlport_resp_ack    = 1'b1;
          m_ctrlport_resp_status = slv_st;
          m_ctrlport_resp_data   = slv_d;
        end
      end else if (stray_req) begin
        stray_req              = 1'b0;
        m_ctrlport_resp_ack    = 1'b1;
        m_ctrlport_resp_data   = 32'hFFFF_FFFF;
      end
    end
  end

  // Reference: the full access list, cut short at the first faulted access.
  task automatic build_expected(input logic [3:0] slave, input logic [5:0] bits, input logic [31:0] data);
    req_t        full[$];
    logic [31:0] ctrl;
    int          n_polls;
    logic [1:0]  fin_status;
    logic [31:0] fin_data;
    exp_q.delete();
    exp_timeout = 1'b0;
    if (bits == 0 || bits > 32) begin
      exp_status = 2'd1;
      exp_data   = 32'd0;
      return;
    end
    ctrl = 32'h2400 + 32'(bits);
    full.push_back({2'b10, c_BASE + 20'h14, 32'd2});
    full.push_back({2'b10, c_BASE + 20'h18, 32'(2 ** slave)});
    full.push_back({2'b10, c_BASE + 20'h08, data});
    full.push_back({2'b10, c_BASE + 20'h10, ctrl});
    full.push_back({2'b10, c_BASE + 20'h10, ctrl + 32'h100});
    n_polls = (cfg_busy >= c_MAX_POLLS) ? c_MAX_POLLS : cfg_busy + 1;
    repeat (n_polls) full.push_back({2'b01, c_BASE + 20'h10, 32'd0});
    if (cfg_busy >= c_MAX_POLLS) begin
      fin_status = 2'd3;
      fin_data   = 32'd0;
    end else begin
      full.push_back({2'b01, c_BASE, 32'd0});
      fin_status = 2'd0;
      fin_data   = 32'(64'(cfg_rx) % (64'd1 << bits));
    end
    foreach (full[i]) begin
      exp_q.push_back(full[i]);
      if (i == cfg_err_idx) begin
        exp_status = 2'd1;
        exp_data   = cfg_err_data;
        return;
      end
      if (i == cfg_noack_idx) begin
        exp_status  = 2'd2;
        exp_data    = 32'd0;
        exp_timeout = 1'b1;
        return;
      end
    end
    exp_status = fin_status;
    exp_data   = fin_data;
  endtask

  task automatic send_cmd(input logic [3:0] slave, input logic [5:0] bits, input logic [31:0] data);
    int waited;
    got_q.delete();
    slv_idx   = 0;
    slv_polls = 0;
    waited    = 0;
    while (!s_cmd_ready && waited < 50) begin
      @(negedge ctrlport_clk);
      waited++;
    end
    check_value("cmd_ready_idle", s_cmd_ready, 1);
    s_cmd_valid = 1'b1;
    s_cmd_slave = slave;
    s_cmd_bits  = bits;
    s_cmd_data  = data;
    @(negedge ctrlport_clk);
    s_cmd_valid = 1'b0;
    s_cmd_slave = 4'($urandom);
    s_cmd_bits  = 6'($urandom);
    s_cmd_data  = $urandom;
    check_value("cmd_ready_busy", s_cmd_ready, 0);
  endtask

  task automatic run_cmd(input logic [3:0] slave, input logic [5:0] bits, input logic [31:0] data, input int hold);
    int          waited;
    int          vcyc;
    int          lat;
    bit          stable;
    logic [31:0] d0;
    logic [1:0]  s0;
    build_expected(slave, bits, data);
    send_cmd(slave, bits, data);
    waited = 0;
    while (!m_rsp_valid && waited < 500) begin
      @(negedge ctrlport_clk);
      waited++;
    end
    check_value("rsp_valid", m_rsp_valid, 1);
    vcyc = cyc;
    if (exp_timeout) begin
      lat = vcyc - last_strobe_cyc;
      check_value($sformatf("ack_timeout_latency_%0d", lat), (lat >= 9 && lat <= 10), 1);
    end
    check_value("rsp_status", m_rsp_status, exp_status);
    check_value("rsp_data", m_rsp_data, exp_data);
    d0     = m_rsp_data;
    s0     = m_rsp_status;
    stable = 1'b1;
    repeat (hold) begin
      @(negedge ctrlport_clk);
      if (m_rsp_valid !== 1'b1 || m_rsp_data !== d0 || m_rsp_status !== s0 || s_cmd_ready !== 1'b0)
        stable = 1'b0;
    end
    check_value("rsp_hold_stable", stable, 1);
    m_rsp_ready = 1'b1;
    stray_req   = 1'b1;
    @(negedge ctrlport_clk);
    m_rsp_ready = 1'b0;
    check_value("rsp_valid_drop", m_rsp_valid, 0);
    check_value("cmd_ready_next", s_cmd_ready, 1);
    check_value("req_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_value($sformatf("req%0d_kind", i), got_q[i].kind, exp_q[i].kind);
      check_value($sformatf("req%0d_addr", i), got_q[i].addr, exp_q[i].addr);
      check_value($sformatf("req%0d_data", i), got_q[i].data, exp_q[i].data);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_value({tag, "_rsp"}, {s_cmd_ready, m_rsp_valid, m_rsp_status, m_rsp_data}, 64'd0);
    check_value({tag, "_req"}, {m_ctrlport_req_wr, m_ctrlport_req_rd, m_ctrlport_req_addr, m_ctrlport_req_data}, 64'd0);
  endtask

  task automatic set_cfg(input int busy, input int err_idx, input int noack_idx, input logic [31:0] rx);
    cfg_busy      = busy;
    cfg_err_idx   = err_idx;
    cfg_noack_idx = noack_idx;
    cfg_rx        = rx;
    cfg_err_data  = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          waited;
    bit          found;
    bit          saw_rsp;
    logic [5:0]  bits;
    int          pick;

    #2 ctrlport_rst_n = 1'b0;
    #1 check_outputs_zero("reset_state");
    repeat (3) @(negedge ctrlport_clk);
    check_value("ready_in_reset", s_cmd_ready, 0);
    ctrlport_rst_n = 1'b1;
    @(negedge ctrlport_clk);
    check_value("ready_after_reset", s_cmd_ready, 1);

    // Nominal transfer with 10 cycles of response backpressure.
    set_cfg(3, -1, -1, 32'h1234_ABCD);
    run_cmd(4'd3, 6'd16, 32'h0000_A5A5, 10);
    // Illegal lengths.
    set_cfg(0, -1, -1, $urandom);
    run_cmd(4'd5, 6'd0, $urandom, 1);
    run_cmd(4'd5, 6'd33, $urandom, 1);
    // Missing ack on step 0.
    set_cfg(0, -1, 0, $urandom);
    run_cmd(4'd1, 6'd8, $urandom, 0);
    // Error status on step 2.
    set_cfg(0, 2, -1, $urandom);
    run_cmd(4'd7, 6'd12, $urandom, 0);
    // Busy never clears.
    set_cfg(1000, -1, -1, $urandom);
    run_cmd(4'd9, 6'd24, $urandom, 2);
    // Full width, no masking.
    set_cfg(0, -1, -1, $urandom);
    run_cmd(4'd15, 6'd32, $urandom, 0);

    // Reset while the poll read is outstanding.
    set_cfg(3, -1, -1, $urandom);
    send_cmd(4'd2, 6'd10, $urandom);
    found  = 1'b0;
    waited = 0;
    while (!found && waited < 200) begin
      @(negedge ctrlport_clk);
      #1;
      foreach (got_q[i]) if (got_q[i].kind == 2'b01 && got_q[i].addr == c_BASE + 20'h10) found = 1'b1;
      waited++;
    end
    check_value("poll_reached", found, 1);
    ctrlport_rst_n = 1'b0;
    #1 check_outputs_zero("mid_reset");
    repeat (2) @(negedge ctrlport_clk);
    ctrlport_rst_n = 1'b1;
    @(negedge ctrlport_clk);
    check_value("ready_after_mid_reset", s_cmd_ready, 1);
    saw_rsp = 1'b0;
    repeat (20) begin
      @(negedge ctrlport_clk);
      if (m_rsp_valid) saw_rsp = 1'b1;
    end
    check_value("no_rsp_after_reset", saw_rsp, 0);

    // Randomized commands.
    for (int n = 0; n < 40; n++) begin
      set_cfg(($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, 3)), -1, -1, $urandom);
      pick = $urandom_range(0, 9);
      if (pick <= 1)      cfg_err_idx   = $urandom_range(0, 9);
      else if (pick == 2) cfg_noack_idx = $urandom_range(0, 9);
      if ($urandom_range(0, 5) == 0) bits = ($urandom_range(0, 1) == 1) ? 6'd0 : 6'($urandom_range(33, 63));
      else                           bits = 6'($urandom_range(1, 32));
      run_cmd(4'($urandom), bits, $urandom, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
